// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT predictor. Fetch-side lookup is combinational;
// execute-side resolution updates one entry per cycle and drives the flush/redirect.

module bp_entry #(
  parameter int TAGW = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd_en,
  input  logic            taken,
  input  logic [TAGW-1:0] tag_i,
  input  logic [31:0]     tgt_i,
  output logic            valid_o,
  output logic [TAGW-1:0] tag_o,
  output logic [31:0]     tgt_o,
  output logic [1:0]      ctr_o
);
  logic            valid_q, valid_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [31:0]     tgt_q, tgt_d;
  logic [1:0]      ctr_q, ctr_d;
  logic            hit;

  assign hit = valid_q && (tag_q == tag_i);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (upd_en) begin
      if (hit) begin
        if (taken) begin
          tgt_d = tgt_i;
          if (ctr_q != 2'd3) ctr_d = ctr_q + 2'd1;
        end else if (ctr_q != 2'd0) begin
          ctr_d = ctr_q - 2'd1;
        end
      end else if (taken) begin
        // Miss-and-taken allocates as weakly taken; miss-and-not-taken leaves the entry alone.
        valid_d = 1'b1;
        tag_d   = tag_i;
        tgt_d   = tgt_i;
        ctr_d   = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign tgt_o   = tgt_q;
  assign ctr_o   = ctr_q;
endmodule

module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        ValidE,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);
  localparam int TAGW = 30 - IDXW;

  logic [IDXW-1:0] idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            unused_pcf;

  assign idx_f      = PCF[IDXW+1:2];
  assign tag_f      = PCF[31:IDXW+2];
  assign idx_e      = PCE[IDXW+1:2];
  assign tag_e      = PCE[31:IDXW+2];
  assign unused_pcf = ^PCF[1:0];

  logic [ENTRIES-1:0]           ent_vld, ent_upd;
  logic [ENTRIES-1:0][TAGW-1:0] ent_tag;
  logic [ENTRIES-1:0][31:0]     ent_tgt;
  logic [ENTRIES-1:0][1:0]      ent_ctr;

  logic is_br, resolve, nonbr_v;

  // Codes 0 and 7 are both non-branches.
  assign is_br   = (BranchTypeE != 3'd0) && (BranchTypeE != 3'd7);
  assign resolve = ValidE && is_br;
  assign nonbr_v = ValidE && !is_br;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign ent_upd[g] = resolve && (idx_e == IDXW'(g));
    bp_entry #(.TAGW(TAGW)) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd_en (ent_upd[g]),
      .taken  (BranchE),
      .tag_i  (tag_e),
      .tgt_i  (BrTargetE),
      .valid_o(ent_vld[g]),
      .tag_o  (ent_tag[g]),
      .tgt_o  (ent_tgt[g]),
      .ctr_o  (ent_ctr[g])
    );
  end

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    PredTakenF  = ent_vld[idx_f] && (ent_tag[idx_f] == tag_f) && ent_ctr[idx_f][1];
    PredTargetF = PredTakenF ? ent_tgt[idx_f] : 32'd0;
  end

  always_comb begin
    MispredictE = 1'b0;
    RedirectPCE = 32'd0;
    if (resolve)
      MispredictE = (BranchE != PredTakenE) ||
                    (BranchE && PredTakenE && (PredTargetE != BrTargetE));
    else if (nonbr_v)
      MispredictE = PredTakenE;
    if (MispredictE)
      RedirectPCE = (resolve && BranchE) ? BrTargetE : PCE + 32'd4;
  end

  logic [31:0] branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (resolve && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (MispredictE && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares against the live outputs.

module tb_branch_predictor;
  logic        clk, rst_n;
  logic [31:0] PCF, PredTargetF, PCE, BrTargetE, PredTargetE, RedirectPCE, BranchCnt, MissCnt;
  logic        PredTakenF, ValidE, BranchE, PredTakenE, MispredictE;
  logic [2:0]  BranchTypeE;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ValidE(ValidE), .PCE(PCE), .BranchTypeE(BranchTypeE), .BranchE(BranchE),
    .BrTargetE(BrTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE), .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_PTK = 0, S_PTG = 1, S_MIS = 2, S_RED = 3, S_BC = 4, S_MC = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      S_PTK:   return {31'd0, PredTakenF};
      S_PTG:   return PredTargetF;
      S_MIS:   return {31'd0, MispredictE};
      S_RED:   return RedirectPCE;
      S_BC:    return BranchCnt;
      default: return MissCnt;
    endcase
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  // Monitor: outputs are combinational, so they are valid by the falling edge.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        c   = sb_q.pop_front();
        act = dut_val(c.sel);
        n_chk++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ValidE = 0; PCE = 0; BranchTypeE = 0; BranchE = 0;
    BrTargetE = 0; PredTakenE = 0; PredTargetE = 0;
  endtask

  task automatic res(input logic [31:0] pc, input logic [2:0] ty, input logic br,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ValidE = 1; PCE = pc; BranchTypeE = ty; BranchE = br;
    BrTargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; PCF = 32'h100; idle();
    push("rst_ptk", S_PTK, 0); push("rst_ptg", S_PTG, 0);
    push("rst_bc", S_BC, 0);   push("rst_mc", S_MC, 0);
    push("rst_mis", S_MIS, 0);
    repeat (2) step();
    rst_n = 1;

    // First taken resolve allocates, visible next cycle
    res(32'h100, 3'd1, 1, 32'h80, 0, 0);
    push("c1_ptk", S_PTK, 0); push("c1_mis", S_MIS, 1); push("c1_red", S_RED, 32'h80);
    step();
    // Not-taken while predicted taken; lookup still shows pre-edge state
    res(32'h100, 3'd1, 0, 32'h80, 1, 32'h80);
    push("c2_ptk", S_PTK, 1); push("c2_ptg", S_PTG, 32'h80);
    push("c2_bc", S_BC, 1);   push("c2_mc", S_MC, 1);
    push("c2_mis", S_MIS, 1); push("c2_red", S_RED, 32'h104);
    step();
    res(32'h100, 3'd1, 0, 32'h80, 0, 0);
    push("c3_ptk", S_PTK, 0); push("c3_ptg", S_PTG, 0);
    push("c3_mis", S_MIS, 0); push("c3_red", S_RED, 0);
    push("c3_bc", S_BC, 2);   push("c3_mc", S_MC, 2);
    step();
    // Four taken resolves from counter 0
    res(32'h100, 3'd1, 1, 32'h80, 0, 0);
    push("c4_ptk", S_PTK, 0); push("c4_mis", S_MIS, 1); push("c4_red", S_RED, 32'h80);
    push("c4_bc", S_BC, 3);
    step();
    push("c5_ptk", S_PTK, 0); push("c5_mis", S_MIS, 1);
    step();
    res(32'h100, 3'd1, 1, 32'h80, 1, 32'h80);
    push("c6_ptk", S_PTK, 1); push("c6_ptg", S_PTG, 32'h80);
    push("c6_mis", S_MIS, 0); push("c6_red", S_RED, 0);
    step();
    push("c7_ptk", S_PTK, 1); push("c7_mis", S_MIS, 0);
    step();
    // Saturated at 3: one not-taken leaves it weakly taken
    res(32'h100, 3'd1, 0, 32'h80, 1, 32'h80);
    push("c8_mis", S_MIS, 1); push("c8_red", S_RED, 32'h104);
    push("c8_bc", S_BC, 7);   push("c8_mc", S_MC, 4);
    step();
    // Hit with wrong target
    res(32'h100, 3'd1, 1, 32'h90, 1, 32'h80);
    push("c9_ptk", S_PTK, 1); push("c9_mis", S_MIS, 1); push("c9_red", S_RED, 32'h90);
    step();
    // Same index, different tag replaces the entry
    res(32'h140, 3'd1, 1, 32'h200, 0, 0);
    push("c10_ptk", S_PTK, 1); push("c10_ptg", S_PTG, 32'h90);
    push("c10_mis", S_MIS, 1); push("c10_red", S_RED, 32'h200);
    step();
    idle();
    push("c11_ptk", S_PTK, 0); push("c11_ptg", S_PTG, 0);
    step();
    // Non-branch predicted taken at top of address space
    PCF = 32'h140;
    res(32'hFFFF_FFFC, 3'd0, 1, 32'h300, 1, 32'h44);
    push("c12_ptk", S_PTK, 1); push("c12_ptg", S_PTG, 32'h200);
    push("c12_bc", S_BC, 10);  push("c12_mc", S_MC, 7);
    push("c12_mis", S_MIS, 1); push("c12_red", S_RED, 0);
    step();
    PCF = 32'hFFFF_FFFC;
    ValidE = 0;
    push("c13_ptk", S_PTK, 0); push("c13_bc", S_BC, 10); push("c13_mc", S_MC, 8);
    push("c13_mis", S_MIS, 0); push("c13_red", S_RED, 0);
    step();
    push("c14_bc", S_BC, 10); push("c14_mc", S_MC, 8);
    res(32'h140, 3'd0, 1, 32'h500, 0, 0);
    push("c14_mis", S_MIS, 0);
    step();
    PCF = 32'h140;
    res(32'h140, 3'd7, 1, 32'h500, 0, 0);
    push("c15_mis", S_MIS, 0); push("c15_ptg", S_PTG, 32'h200);
    step();
    // Not-taken miss leaves the table alone
    res(32'h180, 3'd1, 0, 32'h600, 0, 0);
    push("c16_ptg", S_PTG, 32'h200); push("c16_bc", S_BC, 10); push("c16_mis", S_MIS, 0);
    step();
    idle();
    push("c17_ptk", S_PTK, 1); push("c17_ptg", S_PTG, 32'h200);
    push("c17_bc", S_BC, 11);  push("c17_mc", S_MC, 8);
    step();
    // Reset between edges, held across an edge with a taken resolve pending
    res(32'h40, 3'd1, 1, 32'h700, 0, 0);
    rst_n = 0;
    push("rp_ptk", S_PTK, 0); push("rp_ptg", S_PTG, 0);
    push("rp_bc", S_BC, 0);   push("rp_mc", S_MC, 0);
    step();
    rst_n = 1;
    idle();
    PCF = 32'h40;
    push("c19_ptk", S_PTK, 0); push("c19_bc", S_BC, 0); push("c19_mc", S_MC, 0);
    step();
    PCF = 32'h140;
    push("c20_ptk", S_PTK, 0); push("c20_ptg", S_PTG, 0);
    step();
    step();
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
